pipe_hazard_ctrl: RTL and testbench

- Central hazard and sequencing controller for the 5-stage core pipeline (F/D/E/M/W).
- Generates every per-stage stall and flush enable consumed by the stage pipeline registers: load-use, CSR read-after-write, branch redirect, multi-cycle memory wait (with timeout) and trap flush.
- Sits beside the datapath; all stall/flush outputs are combinational from inputs plus registered FSM state.

---
 rtl/pipe_hazard_ctrl.sv | 149 ++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: hazard/sequencing controller for the F/D/E/M/W pipeline.
//   Emits per-stage stall (hold) and flush (bubble) enables for load-use,
//   CSR read-after-write, branch redirect, data-memory wait (with optional
//   timeout -> bus error trap) and trap flush.
// Ports:
//   clk_i, rstn_i                 clock, async active-low reset
//   rs1D_i/rs2D_i/uses_rs*D_i     D-stage source operands
//   csr_readD_i                   D reads a CSR
//   rdE_i, is_loadE_i             E-stage destination / load flag
//   csr_writeE_i, csr_writeM_i    pending CSR writes in E/M
//   branch_takenE_i               E redirects fetch
//   mem_reqM_i, mem_ack_i         M data-memory handshake
//   trapM_i                       trap committed at M
//   stall*_o, flush*_o            stage hold / bubble enables (combinational)
//   redirect_o, bus_err_o, mem_abort_o  single-cycle pulses
//   stall_cnt_o                   wrapping count of cycles with stallD_o=1
module pipe_hazard_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic [4:0]       rs1D_i,
  input  logic [4:0]       rs2D_i,
  input  logic             uses_rs1D_i,
  input  logic             uses_rs2D_i,
  input  logic             csr_readD_i,
  input  logic [4:0]       rdE_i,
  input  logic             is_loadE_i,
  input  logic             csr_writeE_i,
  input  logic             csr_writeM_i,
  input  logic             branch_takenE_i,
  input  logic             mem_reqM_i,
  input  logic             mem_ack_i,
  input  logic             trapM_i,
  output logic             stallF_o,
  output logic             stallD_o,
  output logic             stallE_o,
  output logic             stallM_o,
  output logic             stallW_o,
  output logic             flushD_o,
  output logic             flushE_o,
  output logic             flushM_o,
  output logic             flushW_o,
  output logic             redirect_o,
  output logic             bus_err_o,
  output logic             mem_abort_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  // Counter only needs to reach MEM_TIMEOUT-1, where it saturates.
  localparam int unsigned   TW      = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [TW-1:0] TO_LAST = (MEM_TIMEOUT == 0) ? '0 : TW'(MEM_TIMEOUT - 1);
  localparam bit            TO_EN   = (MEM_TIMEOUT != 0);

  typedef enum logic [1:0] {RUN, MEM_WAIT, TRAP} state_e;

  state_e            state_q, state_d;
  logic [TW-1:0]     tcnt_q, tcnt_d;
  logic [CNT_W-1:0]  cnt_q;

  logic in_wait, in_trap, mem_miss, tmo_hit, load_use, csr_raw;

  assign in_wait  = (state_q == MEM_WAIT);
  assign in_trap  = (state_q == TRAP);
  assign mem_miss = (state_q == RUN) && mem_reqM_i && !mem_ack_i;
  // An ack in the very cycle the limit is reached still wins over the timeout.
  assign tmo_hit  = TO_EN && in_wait && (tcnt_q == TO_LAST) && !mem_ack_i;
  assign csr_raw  = csr_readD_i && (csr_writeE_i || csr_writeM_i);
  assign load_use = is_loadE_i && (rdE_i != 5'd0) &&
                    ((uses_rs1D_i && (rs1D_i == rdE_i)) ||
                     (uses_rs2D_i && (rs2D_i == rdE_i)));

  // Output priority: trap flush > memory hold > CSR/load-use stall > branch.
  always_comb begin
    stallF_o    = 1'b0;
    stallD_o    = 1'b0;
    stallE_o    = 1'b0;
    stallM_o    = 1'b0;
    stallW_o    = 1'b0;
    flushD_o    = 1'b0;
    flushE_o    = 1'b0;
    flushM_o    = 1'b0;
    flushW_o    = 1'b0;
    redirect_o  = 1'b0;
    bus_err_o   = 1'b0;
    mem_abort_o = 1'b0;
    if (!rstn_i) begin
      // everything quiet while reset is held
    end else if (in_trap || trapM_i) begin
      flushD_o    = 1'b1;
      flushE_o    = 1'b1;
      flushM_o    = 1'b1;
      flushW_o    = 1'b1;
      redirect_o  = in_trap;
      mem_abort_o = in_wait && trapM_i;
    end else if (in_wait || mem_miss) begin
      // M holds the access; W gets a bubble so the retiring op is not repeated.
      stallF_o  = 1'b1;
      stallD_o  = 1'b1;
      stallE_o  = 1'b1;
      stallM_o  = 1'b1;
      flushW_o  = 1'b1;
      bus_err_o = tmo_hit;
    end else if (csr_raw || load_use) begin
      stallF_o = 1'b1;
      stallD_o = 1'b1;
      flushE_o = 1'b1;
    end else if (branch_takenE_i) begin
      flushD_o = 1'b1;
      flushE_o = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    tcnt_d  = '0;
    unique case (state_q)
      RUN: begin
        if (trapM_i)       state_d = TRAP;
        else if (mem_miss) state_d = MEM_WAIT;
      end
      MEM_WAIT: begin
        if (trapM_i)        state_d = TRAP;
        else if (mem_ack_i) state_d = RUN;
        else if (tmo_hit)   state_d = TRAP;
        else if (TO_EN && (tcnt_q != TO_LAST)) tcnt_d = tcnt_q + TW'(1);
        else                tcnt_d = tcnt_q;
      end
      TRAP:    state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= RUN;
      tcnt_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      tcnt_q  <= tcnt_d;
      if (stallD_o) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign stall_cnt_o = cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
module tb_pipe_hazard_ctrl;

  localparam int CW = 4;
  // output vector bit positions
  localparam int SF = 11, SD = 10, SE = 9, SM = 8, SW = 7;
  localparam int FD = 6, FE = 5, FM = 4, FW = 3, RD = 2, BE = 1, MA = 0;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  logic [4:0] rs1D, rs2D, rdE;
  logic uses1, uses2, csr_rd, loadE, csr_wE, csr_wM, brE, req, ack, trap;

  logic a_sF, a_sD, a_sE, a_sM, a_sW, a_fD, a_fE, a_fM, a_fW, a_rd, a_be, a_ma;
  logic b_sF, b_sD, b_sE, b_sM, b_sW, b_fD, b_fE, b_fM, b_fW, b_rd, b_be, b_ma;
  logic [CW-1:0] a_cnt, b_cnt;
  logic [11:0] a_vec, b_vec;
  assign a_vec = {a_sF, a_sD, a_sE, a_sM, a_sW, a_fD, a_fE, a_fM, a_fW, a_rd, a_be, a_ma};
  assign b_vec = {b_sF, b_sD, b_sE, b_sM, b_sW, b_fD, b_fE, b_fM, b_fW, b_rd, b_be, b_ma};

  // A: 4-cycle timeout; B: timeout disabled. Both share stimulus.
  pipe_hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(CW)) u_dut_a (
    .clk_i(clk), .rstn_i(rstn), .rs1D_i(rs1D), .rs2D_i(rs2D),
    .uses_rs1D_i(uses1), .uses_rs2D_i(uses2), .csr_readD_i(csr_rd), .rdE_i(rdE),
    .is_loadE_i(loadE), .csr_writeE_i(csr_wE), .csr_writeM_i(csr_wM),
    .branch_takenE_i(brE), .mem_reqM_i(req), .mem_ack_i(ack), .trapM_i(trap),
    .stallF_o(a_sF), .stallD_o(a_sD), .stallE_o(a_sE), .stallM_o(a_sM), .stallW_o(a_sW),
    .flushD_o(a_fD), .flushE_o(a_fE), .flushM_o(a_fM), .flushW_o(a_fW),
    .redirect_o(a_rd), .bus_err_o(a_be), .mem_abort_o(a_ma), .stall_cnt_o(a_cnt));

  pipe_hazard_ctrl #(.MEM_TIMEOUT(0), .CNT_W(CW)) u_dut_b (
    .clk_i(clk), .rstn_i(rstn), .rs1D_i(rs1D), .rs2D_i(rs2D),
    .uses_rs1D_i(uses1), .uses_rs2D_i(uses2), .csr_readD_i(csr_rd), .rdE_i(rdE),
    .is_loadE_i(loadE), .csr_writeE_i(csr_wE), .csr_writeM_i(csr_wM),
    .branch_takenE_i(brE), .mem_reqM_i(req), .mem_ack_i(ack), .trapM_i(trap),
    .stallF_o(b_sF), .stallD_o(b_sD), .stallE_o(b_sE), .stallM_o(b_sM), .stallW_o(b_sW),
    .flushD_o(b_fD), .flushE_o(b_fE), .flushM_o(b_fM), .flushW_o(b_fW),
    .redirect_o(b_rd), .bus_err_o(b_be), .mem_abort_o(b_ma), .stall_cnt_o(b_cnt));

  int nchk = 0, nfail = 0;
  int nbe_a = 0, nbe_b = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s got=%0h want=%0h @%0t", tag, act, exp, $time);
    end
  endtask

  typedef struct packed {
    logic [11:0]   oa;
    logic [CW-1:0] ca;
    logic [11:0]   ob;
    logic [CW-1:0] cb;
  } exp_t;
  exp_t sb[$];

  // reference model state: 0=RUN 1=MEM_WAIT 2=TRAP
  int            mst[2];
  int            mtc[2];
  logic [CW-1:0] mcnt[2];

  function automatic void model(input int to, input int st, input int tc,
                                output logic [11:0] o, output int nst, output int ntc);
    bit wt, tp, hit;
    o = '0; nst = st; ntc = 0;
    wt  = (st == 1);
    tp  = (st == 2);
    hit = (to != 0) && wt && (tc == to - 1) && !ack;
    if (tp || trap) begin
      o[FD] = 1; o[FE] = 1; o[FM] = 1; o[FW] = 1;
      o[RD] = tp;
      o[MA] = wt && trap;
    end else if (wt || (req && !ack)) begin
      o[SF] = 1; o[SD] = 1; o[SE] = 1; o[SM] = 1; o[FW] = 1;
      o[BE] = hit;
    end else if ((csr_rd && (csr_wE || csr_wM)) ||
                 (loadE && rdE != 0 && ((uses1 && rs1D == rdE) || (uses2 && rs2D == rdE)))) begin
      o[SF] = 1; o[SD] = 1; o[FE] = 1;
    end else if (brE) begin
      o[FD] = 1; o[FE] = 1;
    end
    if (tp)                   nst = 0;
    else if (trap)            nst = 2;
    else if (wt && ack)       nst = 0;
    else if (hit)             nst = 2;
    else if (wt) begin
      nst = 1;
      ntc = (to != 0 && tc < to - 1) ? tc + 1 : tc;
    end else if (req && !ack) nst = 1;
    if (!rstn) o = '0;
  endfunction

  // one cycle: settle, predict, enqueue; advance the model after the edge
  task automatic step();
    exp_t e;
    logic [11:0] o[2];
    int ns[2], nt[2];
    #1;
    model(4, mst[0], mtc[0], o[0], ns[0], nt[0]);
    model(0, mst[1], mtc[1], o[1], ns[1], nt[1]);
    e.oa = o[0]; e.ob = o[1];
    e.ca = rstn ? mcnt[0] : '0;
    e.cb = rstn ? mcnt[1] : '0;
    sb.push_back(e);
    @(posedge clk); #1;
    for (int i = 0; i < 2; i++) begin
      if (!rstn) begin
        mst[i] = 0; mtc[i] = 0; mcnt[i] = '0;
      end else begin
        mst[i] = ns[i]; mtc[i] = nt[i];
        if (o[i][SD]) mcnt[i] = mcnt[i] + 1'b1;
      end
    end
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk("outs_a", 32'(a_vec), 32'(e.oa));
      chk("cnt_a",  32'(a_cnt), 32'(e.ca));
      chk("outs_b", 32'(b_vec), 32'(e.ob));
      chk("cnt_b",  32'(b_cnt), 32'(e.cb));
      if (a_be) nbe_a++;
      if (b_be) nbe_b++;
    end
  end

  task automatic idle();
    rs1D = 0; rs2D = 0; rdE = 0; uses1 = 0; uses2 = 0; csr_rd = 0; loadE = 0;
    csr_wE = 0; csr_wM = 0; brE = 0; req = 0; ack = 0; trap = 0;
  endtask

  logic [CW-1:0] snap;

  initial begin
    rstn = 0;
    idle();
    for (int i = 0; i < 2; i++) begin mst[i] = 0; mtc[i] = 0; mcnt[i] = '0; end
    @(posedge clk); #1;
    step(); step();                      // reset state
    rstn = 1;
    step();

    // load-use on rs2, then rd=x0, then rs1 match but unused
    loadE = 1; rdE = 5; rs2D = 5; uses2 = 1; rs1D = 3; uses1 = 1; step();
    rdE = 0; rs2D = 0; step();
    rdE = 7; rs1D = 7; uses1 = 0; rs2D = 1; step();
    idle(); step();

    // CSR RAW across E then M
    snap = a_cnt;
    csr_rd = 1; csr_wE = 1; step();
    csr_wE = 0; csr_wM = 1; step();
    csr_wM = 0; step();
    chk("csr_cnt_delta", 32'(a_cnt - snap), 32'd2);
    idle();

    brE = 1; step();                     // plain branch
    idle();

    // memory access acked on the 3rd cycle, branch ignored while waiting
    req = 1; step();
    brE = 1; step();
    ack = 1; step();
    idle(); step();

    // no ack: A times out on its 4th MEM_WAIT cycle, then TRAP
    req = 1;
    for (int i = 0; i < 6; i++) step();
    req = 0; ack = 1; step();
    chk("a_buserr_pulses", 32'(nbe_a), 32'd1);
    idle(); step();

    // trap while waiting -> abort, then redirect
    req = 1; step(); step();
    trap = 1; step();
    trap = 0; req = 0; step();
    idle(); step();

    // long wait: B must never report a bus error
    req = 1;
    for (int i = 0; i < 1000; i++) step();
    ack = 1; step();
    idle(); step();
    chk("b_buserr_pulses", 32'(nbe_b), 32'd0);

    // async reset in the middle of a wait
    req = 1; step(); step();
    rstn = 0; step();
    chk("rst_cnt_a", 32'(a_cnt), 32'd0);
    rstn = 1; idle(); step();
    brE = 1; step();
    idle(); step();

    // 16 stall cycles wrap a 4-bit counter back to 0
    csr_rd = 1; csr_wE = 1;
    for (int i = 0; i < 16; i++) step();
    idle(); step();
    chk("cnt_wrap_a", 32'(a_cnt), 32'd0);

    // random mix
    for (int i = 0; i < 300; i++) begin
      rs1D   = 5'($urandom_range(0, 3));
      rs2D   = 5'($urandom_range(0, 3));
      rdE    = 5'($urandom_range(0, 3));
      uses1  = 1'($urandom_range(0, 1));
      uses2  = 1'($urandom_range(0, 1));
      loadE  = 1'($urandom_range(0, 1));
      csr_rd = ($urandom_range(0, 3) == 0);
      csr_wE = ($urandom_range(0, 3) == 0);
      csr_wM = ($urandom_range(0, 3) == 0);
      brE    = loadE ? 1'b0 : ($urandom_range(0, 3) == 0);
      req    = 1'($urandom_range(0, 1));
      ack    = ($urandom_range(0, 2) == 0);
      trap   = ($urandom_range(0, 15) == 0);
      step();
    end
    idle();
    @(negedge clk); #1;
    chk("sb_drain", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
    $finish;
  end

endmodule
